ppu_job_scheduler: RTL

- Shares one PPU (scale/bias/ReLU/truncate/max/quantize pipeline) between NUM_REQ matrix-tile requesters.
- Arbitrates round-robin and stages a full 16-vector partial-sum tile in an internal buffer.
- Bursts the tile into the PPU contiguously with the granted requester's scale/bias, waits for the PPU done pulse, then returns the 136-bit quantized result tagged with the requester ID.
- Sits between the array output collectors and the PPU.

---
 rtl/ppu_job_scheduler.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ppu_job_scheduler.sv
// ppu_job_scheduler: round-robin sharing of one PPU among NUM_REQ tile requesters; optional per-requester job counters under PPU_SCHED_PERF_EN.
// Latency: gnt 1 cycle after req seen in IDLE; first ppu_valid 1 cycle after last FILL beat; out_valid 1 cycle after ppu_done.
// Backpressure: in_ready only while filling the tile buffer; result held in DRAIN until out_ready, no new grant meanwhile.
module ppu_job_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int BEATS   = 16,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [8*NUM_REQ-1:0]  req_scale,
   input  logic [8*NUM_REQ-1:0]  req_bias,
   output logic [NUM_REQ-1:0]    gnt,
   input  logic [383:0]          in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [383:0]          ppu_partial_sum,
   output logic [7:0]            ppu_scale,
   output logic [7:0]            ppu_bias,
   output logic                  ppu_valid,
   input  logic                  ppu_done,
   input  logic [135:0]          ppu_output_data,
   output logic [135:0]          out_data,
   output logic [1:0]            out_id,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  err_timeout,
   output logic [16*NUM_REQ-1:0] perf_jobs
);

   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
   localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_GRANT, S_FILL, S_BURST, S_WAIT, S_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    win_q;
   logic [1:0]    rr_q;
   logic [7:0]    scale_q, bias_q;
   logic [BW-1:0] wr_q, rd_q;
   logic [TW-1:0] tcnt_q;
   logic [383:0]  buf_mem [BEATS];

   logic          any_req;
   logic [1:0]    pick;
   int            best;
   logic [7:0]    sel_scale, sel_bias;

   // Round-robin pick: requester with the smallest distance at/after the pointer.
   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      best    = NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req[k] && (((k - int'(rr_q) + NUM_REQ) % NUM_REQ) < best)) begin
            best    = (k - int'(rr_q) + NUM_REQ) % NUM_REQ;
            pick    = 2'(k);
            any_req = 1'b1;
         end
      end
   end

   // Winner's scale/bias, sampled during the GRANT cycle.
   always_comb begin
      sel_scale = '0;
      sel_bias  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_q == 2'(k)) begin
            sel_scale = req_scale[8*k +: 8];
            sel_bias  = req_bias[8*k +: 8];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state and state-decoded outputs.
   always_comb begin
      state_d         = state_q;
      in_ready        = 1'b0;
      ppu_valid       = 1'b0;
      ppu_partial_sum = '0;
      ppu_scale       = '0;
      ppu_bias        = '0;
      out_valid       = 1'b0;
      busy            = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (any_req) state_d = S_GRANT;
         end
         S_GRANT: begin
            ppu_scale = sel_scale;
            ppu_bias  = sel_bias;
            state_d   = S_FILL;
         end
         S_FILL: begin
            in_ready  = 1'b1;
            ppu_scale = scale_q;
            ppu_bias  = bias_q;
            if (in_valid && wr_q == LAST_BEAT) state_d = S_BURST;
         end
         S_BURST: begin
            ppu_partial_sum = buf_mem[rd_q];
            ppu_valid       = (rd_q == '0);
            ppu_scale       = scale_q;
            ppu_bias        = bias_q;
            if (rd_q == LAST_BEAT) state_d = S_WAIT;
         end
         S_WAIT: begin
            ppu_scale = scale_q;
            ppu_bias  = bias_q;
            if (ppu_done)                 state_d = S_DRAIN;
            else if (tcnt_q == LAST_WAIT) state_d = S_IDLE;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Grant pulse, job context, beat/timeout counters and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt         <= '0;
         win_q       <= '0;
         rr_q        <= '0;
         scale_q     <= '0;
         bias_q      <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         tcnt_q      <= '0;
         out_data    <= '0;
         out_id      <= '0;
         err_timeout <= 1'b0;
      end else begin
         gnt <= '0;
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  gnt   <= NUM_REQ'(1) << pick;
                  win_q <= pick;
               end
            end
            S_GRANT: begin
               scale_q <= sel_scale;
               bias_q  <= sel_bias;
               rr_q    <= (int'(win_q) == NUM_REQ - 1) ? 2'd0 : win_q + 2'd1;
               wr_q    <= '0;
               rd_q    <= '0;
            end
            S_FILL: begin
               if (in_valid) wr_q <= (wr_q == LAST_BEAT) ? '0 : wr_q + BEAT_ONE;
            end
            S_BURST: begin
               rd_q   <= (rd_q == LAST_BEAT) ? '0 : rd_q + BEAT_ONE;
               tcnt_q <= '0;
            end
            S_WAIT: begin
               if (ppu_done) begin
                  out_data <= ppu_output_data;
                  out_id   <= win_q;
               end else if (tcnt_q == LAST_WAIT) begin
                  err_timeout <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + WAIT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Tile buffer: contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (state_q == S_FILL && in_valid) buf_mem[wr_q] <= in_data;
   end

`ifdef PPU_SCHED_PERF_EN
   // Per-requester completed-job counters, bumped on each result handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_jobs <= '0;
      end else if (state_q == S_DRAIN && out_ready) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (out_id == 2'(k)) perf_jobs[16*k +: 16] <= perf_jobs[16*k +: 16] + 16'd1;
         end
      end
   end
`else
   assign perf_jobs = '0;
`endif

endmodule
